clk_div_ctrl: RTL and testbench
===============================

CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

Interface
REQ-001 The block SHALL have parameter CNT_WIDTH, default 16: width of the half-period counter and of the divisor registers.
REQ-002 The block SHALL have parameter DEFAULT_HALF, default 2604: half-period in clk cycles after reset (50 MHz to 9600 Hz); legal range 1..2^CNT_WIDTH-1.
REQ-003 clk  input  1  system clock; all state changes on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 en  input  1  run request; level-sensitive.
REQ-006 cfg_valid  input  1  divisor update request.
REQ-007 cfg_half  input  CNT_WIDTH  requested half-period in clk cycles.
REQ-008 cfg_ready  output  1  update accepted on the same edge that samples cfg_valid=1.
REQ-009 new_clk  output  1  registered divided clock, 50% duty, period 2*H clk cycles.
REQ-010 tick  output  1  registered one-cycle pulse, coincident with each 0->1 transition of new_clk.
REQ-011 active  output  1  high whenever the state is not IDLE.

Function
REQ-012 The block SHALL hold registers H (active half-period), P (pending half-period), pv (pending-valid), cnt (CNT_WIDTH bits) and a state in {IDLE, RUN, STOP}.
REQ-013 The block SHALL drive cfg_ready = !pv combinationally; an accept is cfg_valid && cfg_ready.
REQ-014 The block SHALL treat cfg_half = 0 as 1 on accept (clamp); no other value changes.
REQ-015 On an accept in IDLE, the block SHALL load H directly on the accept edge; pv stays 0.
REQ-016 On an accept in RUN or STOP, the block SHALL load P and set pv=1; H is unchanged.
REQ-017 In IDLE the block SHALL keep cnt=0, new_clk=0 and tick=0; en=1 moves it to RUN on the next edge with cnt=0.
REQ-018 In RUN and STOP the block SHALL increment cnt each cycle while cnt != H-1; at cnt == H-1 it clears cnt and toggles new_clk.
REQ-019 The block SHALL assert tick for exactly the cycle in which new_clk is first 1 after a toggle.
REQ-020 At a toggle edge where new_clk goes 1->0 with pv=1, the block SHALL load H<=P and clear pv; the next period uses the new H from cnt=0. Updates never apply mid-period.
REQ-021 In RUN, en=0 SHALL move the block to STOP on the next edge if new_clk=1, and to IDLE otherwise (cnt cleared).
REQ-022 In STOP, counting SHALL continue; at the 1->0 toggle the block goes to IDLE, and a pending update is applied on that same edge.
REQ-023 In STOP, en=1 SHALL return the block to RUN with no disturbance to cnt or new_clk.
REQ-024 Latency: with en first sampled high at edge 0 in IDLE, new_clk rises and tick pulses at edge H+1; subsequent edges follow every H cycles.
REQ-025 A simultaneous en rise and accept in IDLE SHALL make the first period use the new value.
REQ-026 All comparisons SHALL be CNT_WIDTH-bit equality; cnt never exceeds H-1, so there is no wrap-around.

Reset
REQ-027 While rst=1, the block SHALL force state=IDLE, cnt=0, H=DEFAULT_HALF, P=0, pv=0, new_clk=0, tick=0, active=0 and cfg_ready=1.
REQ-028 Reset asserted mid-period or with pv=1 SHALL discard the pending update and restore H=DEFAULT_HALF.

Verification
REQ-029 Reset then en=1 with DEFAULT_HALF=2 -> new_clk rises at edge 3, period 4, tick width 1 cycle, active=1 from edge 1.
REQ-030 H=3 running, accept cfg_half=5 while new_clk=1 -> cfg_ready=0 until the 1->0 toggle, then high time 5 cycles; no short pulse.
REQ-031 H=4, en dropped while new_clk=1 -> STOP, new_clk completes its high phase, then IDLE with active=0; en dropped while new_clk=0 -> IDLE next edge.
REQ-032 In STOP, en reasserted -> RUN, new_clk period unchanged (checked against a reference period count).
REQ-033 In IDLE, accept cfg_half=0 and en=1 together -> H=1, new_clk toggles every cycle, tick every 2 cycles.
REQ-034 rst pulsed mid-period with pv=1 -> all outputs 0 immediately, cfg_ready=1; after release and en=1, period 2*DEFAULT_HALF.

Source files
------------

// File: rtl/clk_div_ctrl.sv
// -----------------------------------------------------------------------------
// clk_div_ctrl
// Programmable 50%-duty clock divider with glitch-free divisor updates and
// a graceful stop that always finishes the high phase in progress.
//
// Ports
//   clk        system clock, rising-edge active
//   rst        asynchronous, active-high reset
//   en         run request (level); registered once before the FSM sees it
//   cfg_valid  divisor update request
//   cfg_half   requested half-period in clk cycles (0 is treated as 1)
//   cfg_ready  high while no update is pending; accept = cfg_valid && cfg_ready
//   new_clk    registered divided clock, period 2*H clk cycles
//   tick       one-cycle pulse in the first cycle new_clk is high
//   active     high whenever the controller is not IDLE
// -----------------------------------------------------------------------------
module clk_div_ctrl #(
   parameter int CNT_WIDTH    = 16,
   parameter int DEFAULT_HALF = 2604
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 cfg_valid,
   input  logic [CNT_WIDTH-1:0] cfg_half,
   output logic                 cfg_ready,
   output logic                 new_clk,
   output logic                 tick,
   output logic                 active
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      STOP = 2'd2
   } state_t;

   localparam logic [CNT_WIDTH-1:0] DEF_H = CNT_WIDTH'(DEFAULT_HALF);
   localparam logic [CNT_WIDTH-1:0] ONE   = CNT_WIDTH'(1);

   state_t               state_q, state_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [CNT_WIDTH-1:0] h_q, h_d;
   logic [CNT_WIDTH-1:0] p_q, p_d;
   logic                 pv_q, pv_d;
   logic                 new_clk_q, new_clk_d;
   logic                 tick_q, tick_d;
   logic                 en_q;

   logic                 accept;
   logic [CNT_WIDTH-1:0] cfg_half_cl;
   logic                 wrap;
   logic                 go_idle;

   assign accept      = cfg_valid && !pv_q;
   assign cfg_half_cl = (cfg_half == '0) ? ONE : cfg_half;
   // H is never 0, so H-1 cannot underflow and cnt never passes it.
   assign wrap        = (cnt_q == h_q - ONE);

   // Next-state and datapath decisions.
   // NOTE: every signal written here gets a default first, so no path through
   // the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      h_d       = h_q;
      p_d       = p_q;
      pv_d      = pv_q;
      new_clk_d = new_clk_q;
      tick_d    = 1'b0;
      go_idle   = 1'b0;

      case (state_q)
         IDLE: begin
            cnt_d     = '0;
            new_clk_d = 1'b0;
            // Nothing is running, so a new divisor can take effect at once.
            if (accept) h_d = cfg_half_cl;
            if (en_q)   state_d = RUN;
         end

         RUN, STOP: begin
            if (state_q == RUN)
               // Low phase (or the falling edge itself) can be cut short safely.
               go_idle = !en_q && (!new_clk_q || wrap);
            else
               go_idle = !en_q && wrap && new_clk_q;

            if (go_idle) begin
               state_d   = IDLE;
               cnt_d     = '0;
               new_clk_d = 1'b0;
               // Leave IDLE with nothing pending so cfg_ready stays usable.
               pv_d      = 1'b0;
               if (accept)    h_d = cfg_half_cl;
               else if (pv_q) h_d = p_q;
            end else begin
               state_d = en_q ? RUN : STOP;
               if (wrap) begin
                  cnt_d     = '0;
                  new_clk_d = !new_clk_q;
                  tick_d    = !new_clk_q;
                  // Pending divisor only lands on a falling edge: whole periods.
                  if (new_clk_q && pv_q) begin
                     h_d  = p_q;
                     pv_d = 1'b0;
                  end
               end else begin
                  cnt_d = cnt_q + ONE;
               end
               // accept implies pv_q=0, so this never collides with the apply.
               if (accept) begin
                  p_d  = cfg_half_cl;
                  pv_d = 1'b1;
               end
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of every other flop, independent of process order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         h_q       <= DEF_H;
         p_q       <= '0;
         pv_q      <= 1'b0;
         new_clk_q <= 1'b0;
         tick_q    <= 1'b0;
         en_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         h_q       <= h_d;
         p_q       <= p_d;
         pv_q      <= pv_d;
         new_clk_q <= new_clk_d;
         tick_q    <= tick_d;
         en_q      <= en;
      end
   end

   assign cfg_ready = !pv_q;
   assign new_clk   = new_clk_q;
   assign tick      = tick_q;
   assign active    = (state_q != IDLE);

endmodule

// File: tb/tb_clk_div_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clk_div_ctrl
// Self-checking bench for clk_div_ctrl: directed latency / H=1 sequences,
// then randomized en / cfg / rst traffic compared cycle by cycle against a
// behavioural model built from phase position and half-period arithmetic.
// -----------------------------------------------------------------------------
module tb_clk_div_ctrl;

   localparam int CW   = 8;
   localparam int DEFH = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          en = 1'b0;
   logic          cfg_valid = 1'b0;
   logic [CW-1:0] cfg_half = '0;
   logic          cfg_ready, new_clk, tick, active;

   int n_cmp = 0;
   int n_err = 0;

   clk_div_ctrl #(.CNT_WIDTH(CW), .DEFAULT_HALF(DEFH)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .cfg_valid (cfg_valid),
      .cfg_half  (cfg_half),
      .cfg_ready (cfg_ready),
      .new_clk   (new_clk),
      .tick      (tick),
      .active    (active)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Behavioural model. mode: 0 idle, 1 running, 2 stopping.
   // pos = cycles already spent in the current half-period.
   int m_mode, m_pos, m_half, m_pend, m_pv, m_clk, m_tick, m_en_d;

   task automatic model_reset();
      m_mode = 0; m_pos = 0; m_half = DEFH; m_pend = 0;
      m_pv = 0; m_clk = 0; m_tick = 0; m_en_d = 0;
   endtask

   task automatic model_step();
      int  req;
      bit  acc, half_done, leave;
      if (rst) begin
         model_reset();
         return;
      end
      acc       = cfg_valid && (m_pv == 0);
      req       = (cfg_half == 0) ? 1 : int'(cfg_half);
      half_done = (m_pos + 1 == m_half);
      m_tick    = 0;
      if (m_mode == 0) begin
         if (acc) m_half = req;
         if (m_en_d != 0) begin
            m_mode = 1;
            m_pos  = 0;
         end
      end else begin
         if (m_mode == 1) leave = (m_en_d == 0) && (m_clk == 0 || half_done);
         else             leave = (m_en_d == 0) && half_done && m_clk == 1;
         if (leave) begin
            m_mode = 0; m_pos = 0; m_clk = 0;
            if (acc)        m_half = req;
            else if (m_pv != 0) m_half = m_pend;
            m_pv = 0;
         end else begin
            m_mode = (m_en_d != 0) ? 1 : 2;
            if (half_done) begin
               if (m_clk == 1 && m_pv != 0) begin
                  m_half = m_pend;
                  m_pv   = 0;
               end
               m_tick = (m_clk == 0);
               m_clk  = 1 - m_clk;
               m_pos  = 0;
            end else begin
               m_pos++;
            end
            if (acc) begin
               m_pend = req;
               m_pv   = 1;
            end
         end
      end
      m_en_d = en;
   endtask

   task automatic compare_all(input string where);
      check({where, ".new_clk"},   new_clk,   m_clk);
      check({where, ".tick"},      tick,      m_tick);
      check({where, ".active"},    active,    (m_mode != 0));
      check({where, ".cfg_ready"}, cfg_ready, (m_pv == 0));
   endtask

   // One clock: model advances on the edge, outputs are checked mid-cycle.
   task automatic cycle(input string where);
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_all(where);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; en = 1'b0; cfg_valid = 1'b0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Expected (new_clk, tick, active) after edges 0..8 with DEFAULT_HALF=2
   // and en first sampled at edge 0.
   bit lat_clk [9] = '{0, 0, 0, 1, 1, 0, 0, 1, 1};
   bit lat_tick[9] = '{0, 0, 0, 1, 0, 0, 0, 1, 0};
   bit lat_act [9] = '{0, 1, 1, 1, 1, 1, 1, 1, 1};

   initial begin
      model_reset();
      #1;
      check("reset.new_clk",   new_clk,   0);
      check("reset.tick",      tick,      0);
      check("reset.active",    active,    0);
      check("reset.cfg_ready", cfg_ready, 1);
      do_reset();

      // Start-up latency and period with the default divisor.
      en = 1'b1;
      for (int k = 0; k < 9; k++) begin
         cycle("lat");
         check($sformatf("lat%0d.new_clk", k), new_clk, lat_clk[k]);
         check($sformatf("lat%0d.tick", k),    tick,    lat_tick[k]);
         check($sformatf("lat%0d.active", k),  active,  lat_act[k]);
      end

      // Accept cfg_half=0 together with en rise in IDLE: H clamps to 1.
      do_reset();
      en = 1'b1; cfg_valid = 1'b1; cfg_half = '0;
      cycle("h1");
      cfg_valid = 1'b0;
      cycle("h1");
      for (int k = 0; k < 6; k++) begin
         cycle("h1");
         check($sformatf("h1_%0d.new_clk", k), new_clk, (k % 2 == 0));
         check($sformatf("h1_%0d.tick", k),    tick,    (k % 2 == 0));
      end

      // Pending update while running at H=3: high time of 5 follows it.
      do_reset();
      en = 1'b1; cfg_valid = 1'b1; cfg_half = 8'd3;
      cycle("upd");
      cfg_valid = 1'b0;
      for (int k = 0; k < 8; k++) cycle("upd");
      cfg_valid = 1'b1; cfg_half = 8'd5;
      cycle("upd");
      cfg_valid = 1'b0;
      for (int k = 0; k < 30; k++) cycle("upd");

      // Randomized traffic, including mid-run resets.
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 15) == 0) en = ~en;
         cfg_valid = ($urandom_range(0, 7) == 0);
         cfg_half  = CW'($urandom_range(0, 5));
         if ($urandom_range(0, 399) == 0) begin
            rst = 1'b1;
            #1;
            check("arst.new_clk",   new_clk,   0);
            check("arst.tick",      tick,      0);
            check("arst.active",    active,    0);
            check("arst.cfg_ready", cfg_ready, 1);
            model_reset();
            cycle("rnd_rst");
            rst = 1'b0;
         end else begin
            cycle("rnd");
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
